// File: rtl/tpu_pkg.sv
// ----------------------------------------------------------------------------
// tpu_pkg
//   Shared widths and the row-feeder FSM state type for the systolic
//   array front end.
//   DATA_W       : width of one lane word
//   ROW_ADDR_W   : width of a row index into the activation buffer
//   feeder_state_t : IDLE -> READ -> DRAIN -> IDLE
// ----------------------------------------------------------------------------
package tpu_pkg;

   localparam int unsigned DATA_W     = 32;
   localparam int unsigned ROW_ADDR_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } feeder_state_t;

endpackage

// File: rtl/skew_delay_line.sv
// ----------------------------------------------------------------------------
// skew_delay_line
//   Advance-gated shift register of DEPTH stages, W bits wide.
//   DEPTH=0 is a plain passthrough.
//   i_clk : clock (posedge)
//   i_rst : synchronous active-high reset, clears every stage
//   i_adv : shift enable; all stages hold while low
//   i_d   : stage input
//   o_q   : last stage output
// ----------------------------------------------------------------------------
module skew_delay_line #(
   parameter int unsigned DEPTH = 1,
   parameter int unsigned W     = 33
)(
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_adv,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   if (DEPTH == 0) begin : g_pass
      logic w_unused;
      assign w_unused = &{1'b0, i_clk, i_rst, i_adv};
      assign o_q      = i_d;
   end else begin : g_shift
      logic [W-1:0] r_stage [DEPTH];

      always_ff @(posedge i_clk) begin
         if (i_rst) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
               r_stage[k] <= '0;
            end
         end else if (i_adv) begin
            r_stage[0] <= i_d;
            for (int unsigned k = 1; k < DEPTH; k++) begin
               r_stage[k] <= r_stage[k-1];
            end
         end
      end

      assign o_q = r_stage[DEPTH-1];
   end

endmodule

// File: rtl/systolic_row_feeder.sv
// ----------------------------------------------------------------------------
// systolic_row_feeder
//   Reads num_rows rows starting at base_row from the activation row buffer
//   (1-cycle registered read) and presents each row to the systolic array as
//   a diagonal wavefront: lane i lags lane 0 by i beats. arr_ready is the
//   single global advance; when low, FSM, counters, issue flag, delay lines
//   and output registers all hold, and no buffer read is issued.
//   clk, rst          : clock, synchronous active-high reset
//   start             : request, accepted only in IDLE on an advancing cycle
//   base_row,num_rows : run parameters, sampled on an accepted start
//   busy, done        : run in progress / 1-cycle completion pulse
//   buf_mem_enable    : buffer read enable (combinational)
//   buf_wr_rd         : always 0, read only
//   buf_sel_a         : row index to read
//   buf_row_in        : buffer row output, N x DATA_W, lane 0 in the LSBs
//   arr_ready         : array accepts this cycle
//   arr_data          : registered per-lane data, lane 0 in the LSBs
//   arr_valid         : registered per-lane valid
// ----------------------------------------------------------------------------
module systolic_row_feeder
   import tpu_pkg::*;
#(
   parameter int unsigned A = 60000,
   parameter int unsigned N = 256
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ROW_ADDR_W-1:0] base_row,
   input  logic [ROW_ADDR_W-1:0] num_rows,
   output logic                  busy,
   output logic                  done,
   output logic                  buf_mem_enable,
   output logic                  buf_wr_rd,
   output logic [ROW_ADDR_W-1:0] buf_sel_a,
   input  logic [DATA_W*N-1:0]   buf_row_in,
   input  logic                  arr_ready,
   output logic [DATA_W*N-1:0]   arr_data,
   output logic [N-1:0]          arr_valid
);

   localparam int unsigned           DCNT_W    = (N > 1) ? $clog2(N) : 1;
   localparam logic [ROW_ADDR_W-1:0] LAST_ROW  = ROW_ADDR_W'(A - 1);
   localparam logic [DCNT_W-1:0]     LAST_DCNT = DCNT_W'(N - 1);

   logic                  w_adv;
   feeder_state_t         r_state,   w_state_n;
   logic [ROW_ADDR_W-1:0] r_row_ptr, w_row_ptr_n;
   logic [ROW_ADDR_W-1:0] r_rem,     w_rem_n;
   logic [DCNT_W-1:0]     r_dcnt,    w_dcnt_n;
   logic                  r_busy,    w_busy_n;
   logic                  r_done,    w_done_n;
   logic                  r_v0,      w_v0_n;

   assign w_adv = arr_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_row_ptr <= '0;
         r_rem     <= '0;
         r_dcnt    <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_v0      <= 1'b0;
      end else begin
         r_state   <= w_state_n;
         r_row_ptr <= w_row_ptr_n;
         r_rem     <= w_rem_n;
         r_dcnt    <= w_dcnt_n;
         r_busy    <= w_busy_n;
         r_done    <= w_done_n;
         r_v0      <= w_v0_n;
      end
   end

   // done is a pulse: it clears on the following cycle even when stalled.
   always_comb begin
      w_state_n      = r_state;
      w_row_ptr_n    = r_row_ptr;
      w_rem_n        = r_rem;
      w_dcnt_n       = r_dcnt;
      w_busy_n       = r_busy;
      w_done_n       = 1'b0;
      w_v0_n         = w_adv ? (r_state == READ) : r_v0;
      buf_mem_enable = 1'b0;

      case (r_state)
         IDLE: begin
            if (w_adv && start) begin
               if (num_rows != '0) begin
                  w_state_n   = READ;
                  w_row_ptr_n = base_row;
                  w_rem_n     = num_rows;
                  w_busy_n    = 1'b1;
               end else begin
                  w_done_n    = 1'b1;
               end
            end
         end
         READ: begin
            buf_mem_enable = w_adv;
            if (w_adv) begin
               w_row_ptr_n = (r_row_ptr == LAST_ROW) ? '0 : r_row_ptr + 1'b1;
               w_rem_n     = r_rem - 1'b1;
               if (r_rem == ROW_ADDR_W'(1)) begin
                  w_state_n = DRAIN;
                  w_dcnt_n  = '0;
               end
            end
         end
         DRAIN: begin
            if (w_adv) begin
               if (r_dcnt == LAST_DCNT) begin
                  w_state_n = IDLE;
                  w_busy_n  = 1'b0;
                  w_done_n  = 1'b1;
               end else begin
                  w_dcnt_n  = r_dcnt + 1'b1;
               end
            end
         end
         default: w_state_n = IDLE;
      endcase
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign buf_wr_rd = 1'b0;
   assign buf_sel_a = r_row_ptr;

   // Each lane: {valid, data} through an i-deep delay line, then the output
   // register. Bubbles are forced to zero data before entering the line.
   for (genvar g = 0; g < N; g++) begin : g_lane
      logic [DATA_W:0]   w_din;
      logic [DATA_W:0]   w_dout;
      logic [DATA_W-1:0] r_data;
      logic              r_valid;

      assign w_din = {r_v0, (r_v0 ? buf_row_in[g*DATA_W +: DATA_W] : {DATA_W{1'b0}})};

      skew_delay_line #(
         .DEPTH (g),
         .W     (DATA_W + 1)
      ) u_delay (
         .i_clk (clk),
         .i_rst (rst),
         .i_adv (w_adv),
         .i_d   (w_din),
         .o_q   (w_dout)
      );

      always_ff @(posedge clk) begin
         if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
         end else if (w_adv) begin
            r_data  <= w_dout[DATA_W-1:0];
            r_valid <= w_dout[DATA_W];
         end
      end

      assign arr_data[g*DATA_W +: DATA_W] = r_data;
      assign arr_valid[g]                 = r_valid;
   end

endmodule
